fft_r4_stage_ctrl: RTL and testbench
====================================

FFT_R4_STAGE_CTRL -- requirements
Module: fft_r4_stage_ctrl

Interface
REQ-001 Parameter LOG4N, default 4, log4 of the FFT length N (N=4^LOG4N; default N=256).
REQ-002 Parameter BFLY_LAT, default 7, butterfly input-to-output latency in clocks.
REQ-003 Derived localparam ADDR_W=2*LOG4N, the memory/twiddle index width.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a transform; ignored unless idle.
REQ-007 hold  in  1  stall; freezes issue counters while high.
REQ-008 rd_en  out  1  read strobe for the four butterfly operands this cycle.
REQ-009 rd_base  out  ADDR_W  operand-0 address; operands k=1..3 are at rd_base+k*span.
REQ-010 span  out  ADDR_W  current stage span L=4^(LOG4N-1-stage).
REQ-011 tw_idx  out  ADDR_W  twiddle exponent for operand 1; the ROM returns exponents 2x and 3x for operands 2 and 3.
REQ-012 wr_en  out  1  write strobe for the four butterfly results.
REQ-013 wr_base  out  ADDR_W  result-0 address; results k=1..3 are at wr_base+k*span_wr.
REQ-014 span_wr  out  ADDR_W  span aligned with wr_base.
REQ-015 stage  out  clog2(LOG4N)  index of the active stage.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle pulse after the last write of the last stage.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN, NEXT, FIN.
- IDLE->ISSUE on start: stage=0, g=0, j=0.
- ISSUE->DRAIN after the N/4-th issue.
- DRAIN->NEXT when the in-flight count reaches 0.
- NEXT->ISSUE with stage+1, or NEXT->FIN if stage==LOG4N-1.
- FIN->IDLE with done=1 for one cycle.
REQ-019 In ISSUE with hold=0, the block SHALL issue one butterfly per clock.
- rd_base=g*4L+j, tw_idx=j*4^stage (mod N).
- j increments and wraps at L; g increments on j wrap.
REQ-020 While hold=1, the block SHALL hold rd_en=0 and leave counters unchanged; issue resumes on the next cycle with hold=0.
REQ-021 wr_en, wr_base and span_wr SHALL equal rd_en, rd_base and span delayed by exactly BFLY_LAT clocks through a shift register that runs in every state.
REQ-022 The in-flight counter SHALL increment on rd_en and decrement on wr_en, with both on the same cycle leaving it unchanged.
- Max value is BFLY_LAT.
- DRAIN guarantees no read-after-write hazard between stages.
REQ-023 start SHALL be ignored in every state except IDLE, including the cycle done is high.
REQ-024 All address arithmetic SHALL be unsigned modulo 2^ADDR_W; shifts replace multiplies by powers of 4.

Reset
REQ-025 On rst=1 the block SHALL, on the next edge:
- enter IDLE;
- zero all counters, stage, the in-flight count and the delay line;
- drive rd_en=wr_en=busy=done=0 and all addresses=0.
REQ-026 A reset during ISSUE or DRAIN SHALL abort the transform and produce no wr_en pulses afterwards.

Configuration
REQ-027 When macro FFT_R4_DIGITREV_EN is defined, wr_base during the last stage SHALL be the base-4 digit-reversed form of the delayed rd_base, with span_wr=N/4.
REQ-028 When FFT_R4_DIGITREV_EN is not defined, results SHALL be written in place and the output order SHALL remain digit-reversed.

Structure
REQ-029 State encoding (fft_r4_state_t) and a shared BFLY_LAT default constant SHALL live in the package fft_r4_pkg.
REQ-030 The latency delay line SHALL be a separate sub-module fft_r4_delay_line, parameterised by width and depth.

Verification
REQ-031 Basic transform, LOG4N=2, BFLY_LAT=7, start pulse.
- Stage 0: rd_base 0,1,2,3 with span=4 and tw_idx 0,1,2,3.
- Stage 1: rd_base 0,4,8,12 with span=1 and tw_idx 0.
- done appears exactly once.
REQ-032 Latency: each wr_en SHALL appear exactly 7 clocks after its rd_en, with identical base.
- First stage-1 rd_en SHALL come no earlier than the last stage-0 wr_en plus 1.
REQ-033 Stall: hold high for 3 cycles after the 2nd issue of stage 0.
- No rd_en for those 3 cycles.
- Next rd_base=2; total cycle count rises by 3.
REQ-034 Reset mid-DRAIN: rst during stage 0 DRAIN.
- All outputs are 0 the next cycle.
- No wr_en follows.
- A new start runs a full correct transform.
REQ-035 start while busy SHALL have no effect.
- With FFT_R4_DIGITREV_EN defined and LOG4N=2, last-stage wr_base sequence SHALL be 0,1,2,3 for rd_base 0,4,8,12.

Source files
------------

// File: rtl/fft_r4_pkg.sv
// fft_r4_pkg: state encoding, latency default and digit-reverse helper
// shared by the radix-4 stage controller.
package fft_r4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    NEXT,
    FIN
  } fft_r4_state_t;

  localparam int BFLY_LAT_DEF = 7;

  // Reverse the order of the low 'digits' base-4 digits of a.
  function automatic logic [31:0] digit_rev(
    input logic [31:0] a,
    input int          digits
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) begin
        r[2*(digits-1-i) +: 2] = a[2*i +: 2];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_r4_delay_line.sv
// fft_r4_delay_line: fixed-depth register pipe carrying the read
// strobe and addresses forward to the write side.
module fft_r4_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_r4_stage_ctrl.sv
// fft_r4_stage_ctrl: radix-4 FFT stage sequencer (read/twiddle/write).
// Define FFT_R4_DIGITREV_EN to digit-reverse last-stage write addresses.
module fft_r4_stage_ctrl
  import fft_r4_pkg::*;
#(
  parameter  int LOG4N    = 4,
  parameter  int BFLY_LAT = BFLY_LAT_DEF,
  localparam int ADDR_W   = 2 * LOG4N,
  localparam int STG_W    = (LOG4N > 1) ? $clog2(LOG4N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_base,
  output logic [ADDR_W-1:0] span,
  output logic [ADDR_W-1:0] tw_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] span_wr,
  output logic [STG_W-1:0]  stage,
  output logic              busy,
  output logic              done
);

  localparam int LAST  = LOG4N - 1;
  localparam int CNT_W = $clog2(BFLY_LAT + 1);
  localparam int DW    = 1 + 2 * ADDR_W;
  localparam logic [ADDR_W-1:0] QUARTER =
    ADDR_W'(1) << (ADDR_W - 2);
  localparam logic [ADDR_W-1:0] LAST_CNT =
    QUARTER - ADDR_W'(1);

  fft_r4_state_t state, nxt;

  logic [ADDR_W-1:0] g, j, cnt;
  logic [ADDR_W-1:0] span_cur, base_raw, tw_raw;
  logic [CNT_W-1:0]  inflight;
  logic              last_stg;
  logic [DW-1:0]     dl_q;
  logic [ADDR_W-1:0] dl_base, dl_span;

  assign last_stg = (stage == STG_W'(LAST));
  assign span_cur = ADDR_W'(1) << (2 * (LAST - int'(stage)));
  assign base_raw = (g << (2 * (LAST - int'(stage)) + 2)) + j;
  assign tw_raw   = j << (2 * int'(stage));

  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign rd_en   = (state == ISSUE) && !hold;
  assign rd_base = rd_en ? base_raw : '0;
  assign tw_idx  = rd_en ? tw_raw : '0;
  assign span    = busy ? span_cur : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = ISSUE;
      ISSUE:   if (!hold && cnt == LAST_CNT) nxt = DRAIN;
      DRAIN:   if (inflight == '0) nxt = NEXT;
      NEXT:    nxt = last_stg ? FIN : ISSUE;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
      g     <= '0;
      j     <= '0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      stage <= '0;
      g     <= '0;
      j     <= '0;
      cnt   <= '0;
    end else if (rd_en) begin
      cnt <= cnt + ADDR_W'(1);
      if (j == span_cur - ADDR_W'(1)) begin
        j <= '0;
        g <= g + ADDR_W'(1);
      end else begin
        j <= j + ADDR_W'(1);
      end
    end else if (state == NEXT) begin
      g   <= '0;
      j   <= '0;
      cnt <= '0;
      if (!last_stg) stage <= stage + STG_W'(1);
    end else if (state == FIN) begin
      stage <= '0;
    end
  end

  // Butterflies in flight; DRAIN waits for this to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (rd_en && !wr_en) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!rd_en && wr_en) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  fft_r4_delay_line #(
    .W     (DW),
    .DEPTH (BFLY_LAT)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d   ({rd_en, rd_base, span}),
    .q   (dl_q)
  );

  assign {wr_en, dl_base, dl_span} = dl_q;

`ifdef FFT_R4_DIGITREV_EN
  always_comb begin
    wr_base = dl_base;
    span_wr = dl_span;
    if (wr_en && last_stg) begin
      wr_base = ADDR_W'(digit_rev(32'(dl_base), LOG4N));
      span_wr = QUARTER;
    end
  end
`else
  assign wr_base = dl_base;
  assign span_wr = dl_span;
`endif

endmodule

// File: tb/tb_fft_r4_stage_ctrl.sv
// tb_fft_r4_stage_ctrl: random stimulus against a schedule-level model
// of the radix-4 stage controller (LOG4N=2, BFLY_LAT=7).
module tb_fft_r4_stage_ctrl;

  localparam int LOG4N = 2;
  localparam int LAT   = 7;
  localparam int AW    = 2 * LOG4N;
  localparam int N     = 1 << AW;
  localparam int LASTS = LOG4N - 1;
  localparam int SW    = (LOG4N > 1) ? $clog2(LOG4N) : 1;
  localparam int P_IDLE  = 0;
  localparam int P_ISSUE = 1;
  localparam int P_DRAIN = 2;
  localparam int P_NEXT  = 3;
  localparam int P_FIN   = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic          hold = 0;
  logic          rd_en, wr_en, busy, done;
  logic [AW-1:0] rd_base, span, tw_idx, wr_base, span_wr;
  logic [SW-1:0] stage;

  fft_r4_stage_ctrl #(
    .LOG4N    (LOG4N),
    .BFLY_LAT (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .hold    (hold),
    .rd_en   (rd_en),
    .rd_base (rd_base),
    .span    (span),
    .tw_idx  (tw_idx),
    .wr_en   (wr_en),
    .wr_base (wr_base),
    .span_wr (span_wr),
    .stage   (stage),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;
  bit armed = 0;

  int ph = P_IDLE;
  int mstage = 0;
  int qb[$];
  int qt[$];
  int h_en[8192];
  int h_base[8192];
  int h_span[8192];
  int h_last[8192];

  int obs_rd[$];
  int obs_rc[$];
  int obs_wb[$];
  int obs_wc[$];
  int n_done = 0;

  int e_rd, e_base, e_tw, e_span, e_busy, e_done;
  int e_wr, e_wb, e_ws, e_lw, inf;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, act, exp);
    end
  endtask

  // Butterfly list of one stage, straight from the g/j definition.
  task automatic load_stage(input int s);
    int l;
    l = 1 << (2 * (LASTS - s));
    qb.delete();
    qt.delete();
    for (int gg = 0; gg < (1 << (2 * s)); gg++) begin
      for (int jj = 0; jj < l; jj++) begin
        qb.push_back((gg * 4 * l + jj) % N);
        qt.push_back((jj * (1 << (2 * s))) % N);
      end
    end
  endtask

  function automatic int drev(input int a);
    int r, x;
    r = 0;
    x = a;
    for (int i = 0; i < LOG4N; i++) begin
      r = r * 4 + x % 4;
      x = x / 4;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      e_busy = (ph != P_IDLE);
      e_rd   = (ph == P_ISSUE) && !hold;
      e_base = e_rd ? qb[0] : 0;
      e_tw   = e_rd ? qt[0] : 0;
      e_span = e_busy ? (1 << (2 * (LASTS - mstage))) : 0;
      e_done = (ph == P_FIN);
      e_wr = 0; e_wb = 0; e_ws = 0; e_lw = 0;
      if (t >= LAT) begin
        e_wr = h_en[t-LAT];
        e_wb = h_base[t-LAT];
        e_ws = h_span[t-LAT];
        e_lw = h_last[t-LAT];
      end
`ifdef FFT_R4_DIGITREV_EN
      if (e_lw != 0) begin
        e_wb = drev(e_wb);
        e_ws = N / 4;
      end
`endif
      check("rd_en",   32'(rd_en),   e_rd);
      check("rd_base", 32'(rd_base), e_base);
      check("tw_idx",  32'(tw_idx),  e_tw);
      check("span",    32'(span),    e_span);
      check("wr_en",   32'(wr_en),   e_wr);
      check("wr_base", 32'(wr_base), e_wb);
      check("span_wr", 32'(span_wr), e_ws);
      check("stage",   32'(stage),   mstage);
      check("busy",    32'(busy),    e_busy);
      check("done",    32'(done),    e_done);

      inf = 0;
      for (int k = 1; k <= LAT; k++) begin
        if (t - k >= 0) inf += h_en[t-k];
      end
      h_en[t]   = e_rd;
      h_base[t] = e_base;
      h_span[t] = e_span;
      h_last[t] = (e_rd != 0 && mstage == LASTS) ? 1 : 0;

      if (rd_en) begin
        obs_rd.push_back(int'(rd_base));
        obs_rc.push_back(t);
      end
      if (wr_en) begin
        obs_wb.push_back(int'(wr_base));
        obs_wc.push_back(t);
      end
      if (done) n_done++;

      if (rst) begin
        for (int k = 0; k < LAT; k++) begin
          if (t - k >= 0) begin
            h_en[t-k] = 0; h_base[t-k] = 0;
            h_span[t-k] = 0; h_last[t-k] = 0;
          end
        end
        ph = P_IDLE;
        mstage = 0;
        qb.delete();
        qt.delete();
      end else begin
        case (ph)
          P_IDLE: if (start) begin
            ph = P_ISSUE;
            mstage = 0;
            load_stage(0);
          end
          P_ISSUE: if (e_rd != 0) begin
            void'(qb.pop_front());
            void'(qt.pop_front());
            if (qb.size() == 0) ph = P_DRAIN;
          end
          P_DRAIN: if (inf == 0) ph = P_NEXT;
          P_NEXT: if (mstage == LASTS) begin
            ph = P_FIN;
          end else begin
            mstage++;
            load_stage(mstage);
            ph = P_ISSUE;
          end
          default: begin
            ph = P_IDLE;
            mstage = 0;
          end
        endcase
      end
      t++;
    end
  end

  task automatic clear_obs();
    obs_rd.delete(); obs_rc.delete();
    obs_wb.delete(); obs_wc.delete();
  endtask

  // One transform; hold high in cycles [h0,h0+hn); optional stray starts.
  task automatic run(input int h0, input int hn, input bit stray,
                     output int lat);
    lat = -1;
    @(posedge clk); #1;
    start = 1;
    hold = 0;
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(posedge clk); #1;
      start = stray && (k % 5 == 2);
      hold = (k >= h0 && k < h0 + hn);
      @(negedge clk);
      if (done) lat = k;
    end
    @(posedge clk); #1;
    start = 0;
    hold = 0;
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout no done within 200 cycles");
    end
  endtask

  int exp_rd[8] = '{0, 1, 2, 3, 0, 4, 8, 12};
  int exp_tw[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
`ifdef FFT_R4_DIGITREV_EN
  int exp_wb[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
  int exp_wb[8] = '{0, 1, 2, 3, 0, 4, 8, 12};
`endif

  task automatic check_seq(input string nm);
    check({nm, "_nrd"}, obs_rd.size(), 8);
    check({nm, "_nwr"}, obs_wb.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_rd.size()) check({nm, "_rd"}, obs_rd[i], exp_rd[i]);
      if (i < obs_wb.size()) check({nm, "_wb"}, obs_wb[i], exp_wb[i]);
      if (i < obs_rd.size() && i < obs_wc.size())
        check({nm, "_lat7"}, obs_wc[i] - obs_rc[i], LAT);
    end
  endtask

  int lat, d0;

  initial begin
    load_stage(0);
    for (int i = 0; i < 4; i++) begin
      check("model_s0_base", qb[i], exp_rd[i]);
      check("model_s0_tw", qt[i], exp_tw[i]);
    end
    load_stage(1);
    for (int i = 0; i < 4; i++) begin
      check("model_s1_base", qb[i], exp_rd[4+i]);
      check("model_s1_tw", qt[i], exp_tw[4+i]);
    end
    qb.delete();
    qt.delete();

    rst = 1;
    @(posedge clk); #1;
    armed = 1;
    @(negedge clk);
    check("reset_outs",
          32'({rd_en, wr_en, busy, done, rd_base, wr_base, tw_idx}), 0);
    @(posedge clk); #1;
    rst = 0;

    clear_obs();
    d0 = n_done;
    run(0, 0, 0, lat);
    check("lat_basic", lat, 27);
    check_seq("basic");
    check("done_once", n_done - d0, 1);
    if (obs_rc.size() == 8 && obs_wc.size() == 8)
      check("raw_gap", 32'(obs_rc[4] >= obs_wc[3] + 1), 1);

    clear_obs();
    run(3, 3, 0, lat);
    check("lat_hold", lat, 30);
    check_seq("hold");
    if (obs_rc.size() == 8)
      check("hold_gap", obs_rc[2] - obs_rc[1], 4);

    clear_obs();
    d0 = n_done;
    run(0, 0, 1, lat);
    check("lat_stray", lat, 27);
    check_seq("stray");
    @(negedge clk);
    check("stray_idle", 32'(busy), 0);
    check("stray_done", n_done - d0, 1);

    @(posedge clk); #1;
    start = 1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 0;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    clear_obs();
    d0 = n_done;
    @(negedge clk);
    check("rst_outs",
          32'({rd_en, wr_en, busy, done, rd_base, wr_base,
               tw_idx, span, span_wr}), 0);
    for (int k = 0; k < 12; k++) @(negedge clk);
    #1;
    check("rst_no_wr", obs_wb.size(), 0);
    check("rst_no_done", n_done - d0, 0);
    clear_obs();
    run(0, 0, 0, lat);
    check("lat_after_rst", lat, 27);
    check_seq("after_rst");

    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1;
    start = 0;
    hold = 0;
    rst = 0;
    for (int k = 0; k < 60; k++) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
